// File: rtl/encoder_4to2_buf.sv
// Registered 4-to-2 priority encoder with a 2-entry output buffer.
// Flags zero-hot / multi-hot lines and keeps a saturating error count.
module encoder_4to2_buf #(
  parameter int CNT_W     = 8,
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_none,
  output logic             out_multi,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // entry layout: {code[1:0], none, multi}
  logic [3:0] head_q, head_d;
  logic [3:0] tail_q, tail_d;
  logic       in_ready_q, in_ready_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [1:0] code;
  logic       none;
  logic       multi;
  logic [3:0] entry;
  logic       push;
  logic       pop;

  always_comb begin
    code = 2'b00;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 4; i++)
        if (in_d[i]) code = i[1:0];
    end else begin
      for (int i = 3; i >= 0; i--)
        if (in_d[i]) code = i[1:0];
    end
  end

  assign none  = (in_d == 4'b0000);
  // clearing the lowest set bit leaves something iff two or more were set
  assign multi = ((in_d & (in_d - 4'd1)) != 4'b0000);
  assign entry = {code, none, multi};

  assign push = in_valid & in_ready_q;
  assign pop  = out_ready & (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = entry;
        end else if (push) begin
          tail_d  = entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    err_d = err_q;
    if (err_clr)
      err_d = '0;
    else if (push && (none || multi) && (err_q != {CNT_W{1'b1}}))
      err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= 4'b0000;
      tail_q     <= 4'b0000;
      in_ready_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_a     = out_valid & head_q[3];
  assign out_b     = out_valid & head_q[2];
  assign out_none  = out_valid & head_q[1];
  assign out_multi = out_valid & head_q[0];
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_encoder_4to2_buf.sv
// Scoreboard bench: two encoder configurations share one stimulus stream
// and are checked against a queue-based reference model.
module tb_encoder_4to2_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_d = 4'b0000;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       hi_rdy, hi_a, hi_b, hi_none, hi_multi, hi_vld;
  logic [7:0] hi_err;
  logic       lo_rdy, lo_a, lo_b, lo_none, lo_multi, lo_vld;
  logic [1:0] lo_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  encoder_4to2_buf #(.CNT_W(8), .PRIO_HIGH(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .in_d(in_d), .in_valid(in_valid),
    .in_ready(hi_rdy), .out_a(hi_a), .out_b(hi_b),
    .out_none(hi_none), .out_multi(hi_multi), .out_valid(hi_vld),
    .out_ready(out_ready), .err_clr(err_clr), .err_cnt(hi_err)
  );

  encoder_4to2_buf #(.CNT_W(2), .PRIO_HIGH(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_d(in_d), .in_valid(in_valid),
    .in_ready(lo_rdy), .out_a(lo_a), .out_b(lo_b),
    .out_none(lo_none), .out_multi(lo_multi), .out_valid(lo_vld),
    .out_ready(out_ready), .err_clr(err_clr), .err_cnt(lo_err)
  );

  typedef struct {
    logic [1:0] ch;
    logic [1:0] cl;
    logic       none;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  logic m_rdy;
  int   m_err_hi;
  int   m_err_lo;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_entry(input logic [3:0] d);
    exp_t e;
    int ones;
    ones = 0;
    e.ch = 2'd0;
    e.cl = 2'd0;
    for (int i = 0; i < 4; i++)
      if (d[i]) begin
        ones++;
        e.ch = 2'(i);
      end
    for (int i = 3; i >= 0; i--)
      if (d[i]) e.cl = 2'(i);
    e.none  = (ones == 0);
    e.multi = (ones >= 2);
    return e;
  endfunction

  // reference model: updates on the same edges the DUT sees
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rdy    <= 1'b0;
      m_err_hi <= 0;
      m_err_lo <= 0;
    end else begin
      bit   psh, pp;
      exp_t e;
      psh = in_valid && m_rdy;
      pp  = out_ready && (exp_q.size() != 0);
      if (pp) e = exp_q.pop_front();
      if (psh) exp_q.push_back(ref_entry(in_d));
      if (err_clr) begin
        m_err_hi <= 0;
        m_err_lo <= 0;
      end else if (psh && (in_d == 0 || $countones(in_d) >= 2)) begin
        if (m_err_hi < 255) m_err_hi <= m_err_hi + 1;
        if (m_err_lo < 3) m_err_lo <= m_err_lo + 1;
      end
      m_rdy <= (exp_q.size() < 2);
    end
  end

  // monitor: compares presented head against scoreboard front
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", {hi_vld, lo_vld}, 2'b00);
      chk("rst_rdy", {hi_rdy, lo_rdy}, 2'b00);
      chk("rst_out", {hi_a, hi_b, hi_none, hi_multi}, 4'b0000);
      chk("rst_err", {hi_err, lo_err}, 10'd0);
    end else begin
      chk("hi_rdy", hi_rdy, m_rdy);
      chk("lo_rdy", lo_rdy, m_rdy);
      chk("hi_vld", hi_vld, exp_q.size() != 0);
      chk("lo_vld", lo_vld, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("hi_code", {hi_a, hi_b}, exp_q[0].ch);
        chk("lo_code", {lo_a, lo_b}, exp_q[0].cl);
        chk("hi_flags", {hi_none, hi_multi},
            {exp_q[0].none, exp_q[0].multi});
        chk("lo_flags", {lo_none, lo_multi},
            {exp_q[0].none, exp_q[0].multi});
      end
      chk("hi_err", hi_err, m_err_hi);
      chk("lo_err", lo_err, m_err_lo);
    end
  end

  task automatic drive(input logic v, input logic [3:0] d,
                       input logic ordy, input logic clr);
    in_valid  = v;
    in_d      = d;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot [4];
    logic [3:0] stream [3];
    onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    stream = '{4'b0001, 4'b0100, 4'b1000};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 4'b0000, 1, 0);

    for (int i = 0; i < 4; i++) drive(1, onehot[i], 1, 0);
    drive(0, 4'b0000, 1, 0);

    drive(1, 4'b0110, 1, 0);
    drive(1, 4'b0000, 1, 0);
    drive(0, 4'b0000, 1, 0);
    chk("err_after_flags", hi_err, 8'd2);

    drive(1, 4'b0010, 0, 0);
    drive(1, 4'b1000, 0, 0);
    chk("full_rdy_low", hi_rdy, 1'b0);
    repeat (3) drive(1, 4'b0100, 0, 0);
    drive(1, 4'b0100, 1, 0);
    chk("full_pop_no_push", hi_rdy, 1'b1);
    drive(0, 4'b0000, 1, 0);
    drive(0, 4'b0000, 1, 0);

    for (int i = 0; i < 3; i++) drive(1, stream[i], 1, 0);
    drive(0, 4'b0000, 1, 0);

    for (int i = 0; i < 5; i++) drive(1, 4'b1100, 1, 0);
    chk("lo_sat", lo_err, 2'd3);
    drive(1, 4'b0111, 1, 1);
    chk("clr_wins", {hi_err, lo_err}, 10'd0);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    drive(0, 4'b0000, 1, 0);
    drive(0, 4'b0000, 1, 0);
    drive(1, 4'b0110, 0, 0);
    drive(1, 4'b0001, 0, 0);
    drive(0, 4'b0000, 0, 0);
    chk("pre_rst_vld", hi_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", {hi_vld, lo_vld}, 2'b00);
    chk("async_err", hi_err, 8'd0);
    chk("async_rdy", hi_rdy, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rel", {hi_rdy, lo_rdy}, 2'b11);
    drive(1, 4'b1000, 1, 0);
    drive(0, 4'b0000, 1, 0);
    drive(0, 4'b0000, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_buf.md
Name: encoder_4to2_buf

Overview:
- Inverse of the 2-to-4 decoder: maps a 4-bit line vector {d3,d2,d1,d0} back to the 2-bit select {a,b}.
- Registered priority encoder with valid/ready handshakes on both sides and a 2-entry output buffer.
- Flags zero-hot and multi-hot inputs and keeps a saturating error count.
- Sits between a line-request source and any consumer of the {a,b} select.

Parameters:
CNT_W, 8, width of saturating error counter
PRIO_HIGH, 1, 1: highest set index wins; 0: lowest set index wins

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_d  input  4  line vector; bit i corresponds to d_i
in_valid  input  1  in_d valid this cycle
in_ready  output  1  buffer can accept an entry
out_a  output  1  encoded select MSB (head entry)
out_b  output  1  encoded select LSB (head entry)
out_none  output  1  head entry came from in_d == 0
out_multi  output  1  head entry had more than one bit set
out_valid  output  1  head entry present
out_ready  input  1  consumer accepts head
err_clr  input  1  synchronous clear of err_cnt
err_cnt  output  CNT_W  count of accepted none/multi inputs, saturating

Behaviour:
- Reset is asynchronous and active-low; one clock. While rst_n=0: buffer empty, out_valid=0, out_a=out_b=0, out_none=out_multi=0, err_cnt=0, in_ready=0. in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Encoding: the winning index i gives {out_a,out_b} = i[1:0], so d0→00, d1→01, d2→10, d3→11 (exact inverse of the decoder's {a,b}→d_i mapping).
- With PRIO_HIGH=1, in_d=0110 gives 10. With PRIO_HIGH=0, it gives 01.
- in_d=0000: code 00, out_none=1.
- Flag rule: popcount ≥2 gives out_multi=1; otherwise out_multi=0.
- Input accept: in_valid & in_ready at a rising edge. The entry {code, none, multi} is written at the buffer tail.
- Output pop: out_valid & out_ready at a rising edge.
- Latency: an input accepted at edge N appears on outputs after edge N when the buffer was empty. There is no combinational in→out path.
- Buffer states and transitions (count):
  - EMPTY(0) → ONE on push.
  - ONE(1) → EMPTY on pop only; → FULL on push only; stays ONE on push+pop (head becomes the new entry).
  - FULL(2) → ONE on pop. Push is impossible in FULL.
- in_ready = (count < 2), registered from state. It does not depend on out_ready. In FULL, a simultaneous pop does not allow a push in that same cycle.
- out_valid = (count ≠ 0). Head outputs stay stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO; there is no drop or overwrite.
- err_cnt increments by 1 on each accepted input with none or multi set. It saturates at 2^CNT_W−1.
- err_clr=1 forces err_cnt to 0 on the next edge. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- in_d is ignored when in_valid=0.
- Reset mid-operation: buffered entries are discarded immediately (asynchronously) and the block returns to the reset values above.

Test Plan:
- Reset, then apply in_d=0001,0010,0100,1000 one per cycle with out_ready=1 → {a,b}=00,01,10,11, each one cycle after accept; none=multi=0; err_cnt=0.
- PRIO_HIGH=1: in_d=0110 → {a,b}=10, multi=1, err_cnt=1. in_d=0000 → 00, none=1, err_cnt=2. Repeat with PRIO_HIGH=0: 0110 → 01.
- out_ready=0: push 0010 then 1000 → in_ready drops to 0 after the second accept; head holds 01. A third in_valid is not accepted. Release out_ready → 01 then 11 in order; in_ready returns to 1.
- ONE state with simultaneous push+pop each cycle, streaming 0001,0100,1000 → outputs 00,10,11 back-to-back; count stays 1.
- CNT_W=2: 5 accepted multi-hot inputs → err_cnt saturates at 3. Assert err_clr in the same cycle as a multi-hot accept → err_cnt=0.
- Fill to FULL, then pulse rst_n low mid-cycle → out_valid=0 and err_cnt=0 immediately, without a clock edge; in_ready=1 after the first edge following release.
